uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the transmit FIFO depth in bytes; legal values are powers of 2 from 2 to 16.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port wr_data, input, 1 bit: single-cycle strobe that pushes din into the FIFO.
REQ-005 SHALL have port din, input, 8 bits: byte to enqueue.
REQ-006 SHALL have port wr_cfg, input, 1 bit: single-cycle strobe that writes cfg into the pending config register.
REQ-007 SHALL have port cfg, input, 8 bits: [0]=bit8, [1]=pen, [2]=ohel, [3]=reserved, [7:4]=baud_sel.
REQ-008 SHALL have port clr_ovf, input, 1 bit: clears the sticky overflow flag.
REQ-009 SHALL have port txrdy, input, 1 bit: tx_engine ready (1 = idle, can accept ld).
REQ-010 SHALL have port ld, output, 1 bit: one-cycle load pulse to tx_engine.
REQ-011 SHALL have port out_port, output, 8 bits: byte presented to tx_engine, registered.
REQ-012 SHALL have ports bit8, pen and ohel, outputs, 1 bit each: active frame config to tx_engine.
REQ-013 SHALL have port baud_rate, output, 20 bits: active baud divisor to tx_engine.
REQ-014 SHALL have ports full and empty, outputs, 1 bit each; count, output, 5 bits: FIFO occupancy.
REQ-015 SHALL have ports busy and overflow, outputs, 1 bit each: busy = FSM not IDLE; overflow = sticky write-dropped flag.

Function
REQ-016 SHALL have a FIFO of DEPTH x 8 with wrapping read/write pointers and count in 0..DEPTH; full = (count==DEPTH); empty = (count==0).
REQ-017 SHALL drop a wr_data while full with no pop in the same cycle, leave the FIFO unchanged, and set overflow.
REQ-018 SHALL accept a wr_data while full when a pop occurs in the same cycle, leaving count unchanged.
REQ-019 SHALL change count by 0 on a simultaneous push and pop when not full; SHALL never pop when empty.
REQ-020 SHALL clear overflow on clr_ovf; if clr_ovf and a dropped write coincide, overflow SHALL be set (set wins).
REQ-021 SHALL implement FSM states IDLE, LOAD, WAIT_BUSY and WAIT_RDY.
REQ-022 IDLE SHALL copy pending config into the active bit8/pen/ohel/baud_rate registers every cycle, so the active config never changes mid-frame.
REQ-023 IDLE -> LOAD SHALL occur when !empty && txrdy; on that edge out_port <= FIFO head and the head is popped.
REQ-024 LOAD SHALL assert ld for exactly one cycle and then go to WAIT_BUSY; ld SHALL be 0 in every other state.
REQ-025 WAIT_BUSY SHALL go to WAIT_RDY when txrdy==0.
REQ-026 WAIT_BUSY SHALL return to IDLE after 16 consecutive cycles with txrdy==1, as a lost-load recovery that leaves the FIFO untouched.
REQ-027 WAIT_RDY SHALL go to IDLE when txrdy==1.
REQ-028 SHALL make latency from a push into an empty FIFO with the controller idle to ld==1 equal to 2 cycles (push edge, IDLE->LOAD edge).
REQ-029 SHALL decode baud_sel to baud_rate as: 0:333333, 1:83333, 2:41667, 3:20833, 4:10417, 5:5208, 6:2604, 7:1736, 8:868, 9:434, 10:217, 11:109, 12-15:868.
REQ-030 SHALL give wr_cfg, when coincident with any FSM state, priority only over the pending register; active config SHALL update only in IDLE.

Reset
REQ-031 On reset, FSM SHALL go to IDLE and the FIFO pointers and count SHALL go to 0, so empty=1, full=0 and busy=0.
REQ-032 On reset, ld, overflow, out_port, bit8, pen and ohel SHALL be 0, and pending baud_sel and active baud_rate SHALL be 8 (868).
REQ-033 Reset asserted mid-frame SHALL discard queued bytes and abandon the in-progress handshake without asserting ld.

Verification
REQ-034 SHALL verify that after reset with txrdy=1, pushing 8'h3A gives ld=1 exactly 2 cycles later with out_port=8'h3A, and empty=1 after the pop.
REQ-035 SHALL verify that pushing 9 bytes with txrdy=0 holds full=1 and count=8, and sets overflow=1; clr_ovf then gives overflow=0.
REQ-036 SHALL verify that writing cfg=8'hB7 during WAIT_RDY keeps baud_rate=868; after return to IDLE, baud_rate=109 and bit8=pen=ohel=1.
REQ-037 SHALL verify that with a model engine (txrdy low 10 cycles after ld), 3 queued bytes produce 3 ld pulses in FIFO order, each only after txrdy returns high.
REQ-038 SHALL verify that with txrdy held at 1 after ld (lost load), the FSM returns to IDLE after 16 cycles and the next byte is loaded.
REQ-039 SHALL verify that reset asserted in WAIT_BUSY with 4 bytes queued gives count=0, busy=0 and no ld on the next cycle.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: byte FIFO plus load handshake toward a tx engine.
// Frame config is double-buffered so it only changes between frames.
module uart_tx_ctrl #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_data,
   input  logic [7:0]  din,
   input  logic        wr_cfg,
   input  logic [7:0]  cfg,
   input  logic        clr_ovf,
   input  logic        txrdy,
   output logic        ld,
   output logic [7:0]  out_port,
   output logic        bit8,
   output logic        pen,
   output logic        ohel,
   output logic [19:0] baud_rate,
   output logic        full,
   output logic        empty,
   output logic [4:0]  count,
   output logic        busy,
   output logic        overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [4:0] DEPTH_C = 5'(DEPTH);

   typedef enum logic [1:0] {
      IDLE, LOAD, WAIT_BUSY, WAIT_RDY
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      tmo_q, tmo_d;
   logic [7:0]      mem_q [DEPTH];
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [4:0]      cnt_q;
   logic [7:0]      out_q;
   logic [7:0]      pend_q;
   logic            bit8_q, pen_q, ohel_q, ovf_q;
   logic [19:0]     baud_q;
   logic            pop, push, drop;
   logic            unused_rsvd;

   function automatic logic [19:0] baud_dec(input logic [3:0] sel);
      case (sel)
         4'd0:    baud_dec = 20'd333333;
         4'd1:    baud_dec = 20'd83333;
         4'd2:    baud_dec = 20'd41667;
         4'd3:    baud_dec = 20'd20833;
         4'd4:    baud_dec = 20'd10417;
         4'd5:    baud_dec = 20'd5208;
         4'd6:    baud_dec = 20'd2604;
         4'd7:    baud_dec = 20'd1736;
         4'd9:    baud_dec = 20'd434;
         4'd10:   baud_dec = 20'd217;
         4'd11:   baud_dec = 20'd109;
         default: baud_dec = 20'd868;
      endcase
   endfunction

   assign unused_rsvd = pend_q[3];

   assign empty = (cnt_q == 5'd0);
   assign full  = (cnt_q == DEPTH_C);
   assign pop   = (state_q == IDLE) && !empty && txrdy;
   assign push  = wr_data && (!full || pop);
   assign drop  = wr_data && full && !pop;

   always_comb begin
      state_d = state_q;
      tmo_d   = 4'd0;
      unique case (state_q)
         IDLE:      if (pop) state_d = LOAD;
         LOAD:      state_d = WAIT_BUSY;
         WAIT_BUSY: begin
            if (!txrdy) state_d = WAIT_RDY;
            else if (tmo_q == 4'd15) state_d = IDLE;
            else tmo_d = tmo_q + 4'd1;
         end
         WAIT_RDY:  if (txrdy) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Storage array carries no reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         tmo_q   <= 4'd0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= 5'd0;
         out_q   <= 8'h00;
         pend_q  <= 8'h80;
         bit8_q  <= 1'b0;
         pen_q   <= 1'b0;
         ohel_q  <= 1'b0;
         baud_q  <= 20'd868;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop) begin
            out_q  <= mem_q[rptr_q];
            rptr_q <= rptr_q + 1'b1;
         end
         if (push && !pop) cnt_q <= cnt_q + 5'd1;
         else if (pop && !push) cnt_q <= cnt_q - 5'd1;
         if (drop) ovf_q <= 1'b1;
         else if (clr_ovf) ovf_q <= 1'b0;
         if (wr_cfg) pend_q <= cfg;
         if (state_q == IDLE) begin
            bit8_q <= pend_q[0];
            pen_q  <= pend_q[1];
            ohel_q <= pend_q[2];
            baud_q <= baud_dec(pend_q[7:4]);
         end
      end
   end

   assign ld        = (state_q == LOAD);
   assign busy      = (state_q != IDLE);
   assign out_port  = out_q;
   assign bit8      = bit8_q;
   assign pen       = pen_q;
   assign ohel      = ohel_q;
   assign baud_rate = baud_q;
   assign count     = cnt_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: byte scoreboard checked on every ld pulse,
// plus per-scenario checks of FIFO flags, config timing and recovery.
module tb_uart_tx_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_data;
   logic [7:0]  din;
   logic        wr_cfg;
   logic [7:0]  cfg;
   logic        clr_ovf;
   logic        txrdy;
   logic        ld;
   logic [7:0]  out_port;
   logic        bit8, pen, ohel;
   logic [19:0] baud_rate;
   logic        full, empty;
   logic [4:0]  count;
   logic        busy, overflow;

   int errors = 0;
   int checks = 0;
   logic [7:0] sbq[$];

   always #5 clk = ~clk;

   uart_tx_ctrl #(.DEPTH(8)) dut (
      .clk(clk), .reset(reset), .wr_data(wr_data), .din(din),
      .wr_cfg(wr_cfg), .cfg(cfg), .clr_ovf(clr_ovf), .txrdy(txrdy),
      .ld(ld), .out_port(out_port), .bit8(bit8), .pen(pen), .ohel(ohel),
      .baud_rate(baud_rate), .full(full), .empty(empty), .count(count),
      .busy(busy), .overflow(overflow)
   );

   // Every ld must present the oldest byte not yet loaded.
   always @(negedge clk) begin
      if (ld === 1'b1) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_ld: got out_port=%0h want no ld", out_port);
         end else begin
            logic [7:0] e;
            e = sbq.pop_front();
            if (out_port !== e) begin
               errors++;
               $display("FAIL sb_order: got %0h want %0h", out_port, e);
            end
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic run_engine(input int n, input int hold,
                             output int nld, output int gap_min);
      int cyc, last;
      nld = 0; gap_min = 1000; last = -1; cyc = 0;
      txrdy = 1'b1;
      while (nld < n && cyc < 600) begin
         step; cyc++;
         if (ld === 1'b1) begin
            nld++;
            if (last >= 0 && cyc - last < gap_min) gap_min = cyc - last;
            last = cyc;
            txrdy = 1'b0;
            repeat (hold) begin step; cyc++; end
            txrdy = 1'b1;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; wr_data = 0; din = 0; wr_cfg = 0; cfg = 0;
      clr_ovf = 0; txrdy = 1'b1;
      step; step;
      checks++;
      if ({empty, full, busy, ld, overflow} !== 5'b10000) begin
         errors++;
         $display("FAIL rst_flags: got e/f/b/ld/ov=%b want 10000",
                  {empty, full, busy, ld, overflow});
      end
      checks++;
      if (count !== 5'd0 || out_port !== 8'h00) begin
         errors++;
         $display("FAIL rst_data: got count=%0d out=%0h want 0 0", count, out_port);
      end
      checks++;
      if (baud_rate !== 20'd868 || {bit8, pen, ohel} !== 3'b000) begin
         errors++;
         $display("FAIL rst_cfg: got baud=%0d cfg=%b want 868 000",
                  baud_rate, {bit8, pen, ohel});
      end
      reset = 1'b0;
      step;
   endtask

   task automatic test_latency;
      txrdy = 1'b1;
      wr_data = 1'b1; din = 8'h3A; sbq.push_back(8'h3A);
      step;
      wr_data = 1'b0;
      checks++;
      if (ld !== 1'b0) begin
         errors++;
         $display("FAIL lat_early: got ld=%b want 0", ld);
      end
      step;
      checks++;
      if (ld !== 1'b1 || out_port !== 8'h3A || empty !== 1'b1) begin
         errors++;
         $display("FAIL lat_ld: got ld=%b out=%0h empty=%b want 1 3a 1",
                  ld, out_port, empty);
      end
      step;
      checks++;
      if (ld !== 1'b0) begin
         errors++;
         $display("FAIL lat_pulse: got ld=%b want 0", ld);
      end
      txrdy = 1'b0; step; step;
      txrdy = 1'b1; step;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL lat_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_overflow;
      int nld, gap;
      txrdy = 1'b0;
      for (int i = 0; i < 9; i++) begin
         wr_data = 1'b1; din = 8'h10 + 8'(i);
         if (i < 8) sbq.push_back(din);
         step;
      end
      wr_data = 1'b0;
      checks++;
      if (full !== 1'b1 || count !== 5'd8 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_full: got full=%b count=%0d ovf=%b want 1 8 1",
                  full, count, overflow);
      end
      wr_data = 1'b1; din = 8'hFF; clr_ovf = 1'b1;
      step;
      wr_data = 1'b0; clr_ovf = 1'b0;
      checks++;
      if (overflow !== 1'b1 || count !== 5'd8) begin
         errors++;
         $display("FAIL ovf_setwins: got ovf=%b count=%0d want 1 8", overflow, count);
      end
      clr_ovf = 1'b1; step; clr_ovf = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: got ovf=%b want 0", overflow);
      end
      run_engine(8, 3, nld, gap);
      checks++;
      if (nld != 8 || gap != 5) begin
         errors++;
         $display("FAIL ovf_drain: got nld=%0d gap=%0d want 8 5", nld, gap);
      end
      repeat (2) step;
      checks++;
      if (empty !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ovf_empty: got empty=%b busy=%b want 1 0", empty, busy);
      end
   endtask

   task automatic test_cfg;
      txrdy = 1'b1;
      wr_data = 1'b1; din = 8'hAA; sbq.push_back(8'hAA);
      step; wr_data = 1'b0; step;
      checks++;
      if (ld !== 1'b1) begin
         errors++;
         $display("FAIL cfg_ld: got ld=%b want 1", ld);
      end
      txrdy = 1'b0; step; step;
      wr_cfg = 1'b1; cfg = 8'hB7; step; wr_cfg = 1'b0; step;
      checks++;
      if (baud_rate !== 20'd868 || {bit8, pen, ohel} !== 3'b000 || busy !== 1'b1) begin
         errors++;
         $display("FAIL cfg_hold: got baud=%0d cfg=%b busy=%b want 868 000 1",
                  baud_rate, {bit8, pen, ohel}, busy);
      end
      txrdy = 1'b1; step; step;
      checks++;
      if (baud_rate !== 20'd109 || {bit8, pen, ohel} !== 3'b111) begin
         errors++;
         $display("FAIL cfg_apply: got baud=%0d cfg=%b want 109 111",
                  baud_rate, {bit8, pen, ohel});
      end
      wr_cfg = 1'b1; cfg = 8'h00; step; wr_cfg = 1'b0; step;
      checks++;
      if (baud_rate !== 20'd333333 || {bit8, pen, ohel} !== 3'b000) begin
         errors++;
         $display("FAIL cfg_sel0: got baud=%0d cfg=%b want 333333 000",
                  baud_rate, {bit8, pen, ohel});
      end
      wr_cfg = 1'b1; cfg = 8'hC2; step; wr_cfg = 1'b0; step;
      checks++;
      if (baud_rate !== 20'd868 || {bit8, pen, ohel} !== 3'b010) begin
         errors++;
         $display("FAIL cfg_sel12: got baud=%0d cfg=%b want 868 010",
                  baud_rate, {bit8, pen, ohel});
      end
   endtask

   task automatic test_engine;
      int nld, gap;
      txrdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wr_data = 1'b1; din = 8'hC0 + 8'(i * 7);
         sbq.push_back(din);
         step;
      end
      wr_data = 1'b0;
      checks++;
      if (count !== 5'd3) begin
         errors++;
         $display("FAIL eng_count: got %0d want 3", count);
      end
      run_engine(3, 10, nld, gap);
      checks++;
      if (nld != 3 || gap != 12) begin
         errors++;
         $display("FAIL eng_pulses: got nld=%0d gap=%0d want 3 12", nld, gap);
      end
      repeat (2) step;
      checks++;
      if (empty !== 1'b1 || sbq.size() != 0) begin
         errors++;
         $display("FAIL eng_drain: got empty=%b left=%0d want 1 0", empty, sbq.size());
      end
   endtask

   task automatic test_lost_load;
      txrdy = 1'b1;
      wr_data = 1'b1; din = 8'h5C; sbq.push_back(8'h5C); step;
      din = 8'hE1; sbq.push_back(8'hE1); step;
      wr_data = 1'b0;
      checks++;
      if (ld !== 1'b1) begin
         errors++;
         $display("FAIL lost_first: got ld=%b want 1", ld);
      end
      repeat (16) step;
      checks++;
      if (busy !== 1'b1 || count !== 5'd1) begin
         errors++;
         $display("FAIL lost_wait: got busy=%b count=%0d want 1 1", busy, count);
      end
      step;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL lost_timeout: got busy=%b want 0", busy);
      end
      step;
      checks++;
      if (ld !== 1'b1 || out_port !== 8'hE1) begin
         errors++;
         $display("FAIL lost_next: got ld=%b out=%0h want 1 e1", ld, out_port);
      end
      txrdy = 1'b0; step; step;
      txrdy = 1'b1; step;
   endtask

   task automatic test_reset_midframe;
      txrdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wr_data = 1'b1; din = 8'h70 + 8'(i);
         sbq.push_back(din);
         step;
      end
      wr_data = 1'b0;
      checks++;
      if (count !== 5'd4 || busy !== 1'b1 || ld !== 1'b0) begin
         errors++;
         $display("FAIL mid_state: got count=%0d busy=%b ld=%b want 4 1 0",
                  count, busy, ld);
      end
      reset = 1'b1; step; reset = 1'b0;
      sbq.delete();
      checks++;
      if (count !== 5'd0 || busy !== 1'b0 || ld !== 1'b0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: got count=%0d busy=%b ld=%b empty=%b want 0 0 0 1",
                  count, busy, ld, empty);
      end
      step;
      checks++;
      if (ld !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_after: got ld=%b busy=%b want 0 0", ld, busy);
      end
   endtask

   initial begin
      test_reset;
      test_latency;
      test_overflow;
      test_cfg;
      test_engine;
      test_lost_load;
      test_reset_midframe;
      repeat (2) step;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
